// File: rtl/pipe_fifo_stage.sv
// Elastic first-word-fall-through FIFO that re-presents an upstream valid/ready
// stream downstream, with occupancy and flag outputs for credit logic.
module pipe_fifo_stage #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = 3
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_vld,
  output logic                       o_rdy,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_vld,
  input  logic                       i_rdy,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_afull
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic push;
  logic pop;

  // Flags decode the count register only, so o_rdy never depends on i_rdy.
  assign o_full  = (count_q == DEPTH_C);
  assign o_empty = (count_q == '0);
  assign o_afull = (count_q >= AFULL_C);
  assign o_count = count_q;
  assign o_rdy   = ~o_full;
  assign o_vld   = ~o_empty;
  assign o_data  = mem[rd_ptr_q];

  assign push = i_vld & o_rdy;
  assign pop  = o_vld & i_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      // Flush drops everything, including a word offered this same cycle.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally not reset; contents are qualified by count.
  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_flush && push) begin
      mem[wr_ptr_q] <= i_data;
    end
  end

endmodule

// File: tb/tb_pipe_fifo_stage.sv
// Self-checking bench for pipe_fifo_stage: directed vector tables, hand-written
// corner sequences and random traffic against a queue-based reference model.
module tb_pipe_fifo_stage;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AFT   = 3;

  logic             i_clk = 1'b0;
  logic             i_reset, i_vld, i_rdy, i_flush;
  logic [WIDTH-1:0] i_data;
  logic             o_rdy, o_vld, o_full, o_empty, o_afull;
  logic [WIDTH-1:0] o_data;
  logic [2:0]       o_count;

  pipe_fifo_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_vld(i_vld),
    .o_rdy(o_rdy), .o_data(o_data), .o_vld(o_vld), .i_rdy(i_rdy),
    .i_flush(i_flush), .o_count(o_count), .o_full(o_full),
    .o_empty(o_empty), .o_afull(o_afull)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] mq[$];
  logic             stall_pend = 1'b0;
  logic [WIDTH-1:0] stall_data;

  typedef struct {
    logic rst; logic fl; logic v; logic [7:0] d; logic r;
    int cnt; logic vld; logic rdy; logic full; logic afull; logic empty;
    logic dchk; logic [7:0] dexp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference view of the outputs derived purely from the queue contents.
  task automatic check_model();
    int n;
    n = mq.size();
    chk("count", 32'(o_count), 32'(n));
    chk("vld",   32'(o_vld),   32'(n > 0));
    chk("rdy",   32'(o_rdy),   32'(n < DEPTH));
    chk("full",  32'(o_full),  32'(n == DEPTH));
    chk("empty", 32'(o_empty), 32'(n == 0));
    chk("afull", 32'(o_afull), 32'(n >= AFT));
    if (n > 0) chk("head_data", 32'(o_data), 32'(mq[0]));
  endtask

  task automatic cycle(input logic rst, input logic fl, input logic v,
                       input logic [7:0] d, input logic r);
    logic push, pop;
    i_reset = rst; i_flush = fl; i_vld = v; i_data = d; i_rdy = r;
    @(negedge i_clk);
    check_model();
    if (stall_pend) begin
      chk("stall_vld",  32'(o_vld),  32'd1);
      chk("stall_data", 32'(o_data), 32'(stall_data));
    end
    stall_pend = (mq.size() > 0) && !r && !rst && !fl;
    stall_data = o_data;
    push = v && (mq.size() < DEPTH);
    pop  = (mq.size() > 0) && r;
    @(posedge i_clk);
    if (rst || fl) begin
      mq.delete();
    end else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(d);
    end
    #1;
  endtask

  task automatic run_vecs(input string tag, input vec_t vs[]);
    foreach (vs[k]) begin
      cycle(vs[k].rst, vs[k].fl, vs[k].v, vs[k].d, vs[k].r);
      chk({tag, "_count"}, 32'(o_count), 32'(vs[k].cnt));
      chk({tag, "_vld"},   32'(o_vld),   32'(vs[k].vld));
      chk({tag, "_rdy"},   32'(o_rdy),   32'(vs[k].rdy));
      chk({tag, "_full"},  32'(o_full),  32'(vs[k].full));
      chk({tag, "_afull"}, 32'(o_afull), 32'(vs[k].afull));
      chk({tag, "_empty"}, 32'(o_empty), 32'(vs[k].empty));
      if (vs[k].dchk) chk({tag, "_data"}, 32'(o_data), 32'(vs[k].dexp));
      $display("%s vec %0d: count=%0d vld=%0b data=%0h", tag, k, o_count, o_vld, o_data);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t fill_drain[];
    vec_t full_pop[];

    i_reset = 1'b1; i_flush = 1'b0; i_vld = 1'b0; i_rdy = 1'b0; i_data = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_vld",   32'(o_vld),   32'd0);
    chk("rst_rdy",   32'(o_rdy),   32'd1);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_full",  32'(o_full),  32'd0);
    chk("rst_afull", 32'(o_afull), 32'd0);
    $display("reset: vld=%0b rdy=%0b count=%0d", o_vld, o_rdy, o_count);

    //                rst fl v  d      r  cnt vld rdy full af  emp dchk dexp
    fill_drain = '{
      '{1'b0,1'b0,1'b1,8'h11,1'b0, 1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,8'h11},
      '{1'b0,1'b0,1'b1,8'h22,1'b0, 2,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,8'h11},
      '{1'b0,1'b0,1'b1,8'h33,1'b0, 3,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,8'h11},
      '{1'b0,1'b0,1'b1,8'h44,1'b0, 4,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,8'h11},
      '{1'b0,1'b0,1'b0,8'h00,1'b1, 3,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,8'h22},
      '{1'b0,1'b0,1'b0,8'h00,1'b1, 2,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,8'h33},
      '{1'b0,1'b0,1'b0,8'h00,1'b1, 1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,8'h44},
      '{1'b0,1'b0,1'b0,8'h00,1'b1, 0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h00}
    };
    run_vecs("fill", fill_drain);

    // Full with a pop and an offered push: the push must be refused.
    full_pop = '{
      '{1'b0,1'b0,1'b1,8'h11,1'b0, 1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,8'h11},
      '{1'b0,1'b0,1'b1,8'h22,1'b0, 2,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,8'h11},
      '{1'b0,1'b0,1'b1,8'h33,1'b0, 3,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,8'h11},
      '{1'b0,1'b0,1'b1,8'h44,1'b0, 4,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,8'h11},
      '{1'b0,1'b0,1'b1,8'h55,1'b1, 3,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,8'h22},
      '{1'b0,1'b0,1'b1,8'h55,1'b0, 4,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,8'h22},
      '{1'b0,1'b0,1'b0,8'h00,1'b1, 3,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,8'h33},
      '{1'b0,1'b0,1'b0,8'h00,1'b1, 2,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,8'h44},
      '{1'b0,1'b0,1'b0,8'h00,1'b1, 1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,8'h55},
      '{1'b0,1'b0,1'b0,8'h00,1'b1, 0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h00}
    };
    run_vecs("fullpop", full_pop);

    // Streaming: output tracks input with one cycle of latency, count stays 1.
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'(k), 1'b1);
      chk("stream_count", 32'(o_count), 32'd1);
      chk("stream_data",  32'(o_data),  32'(k));
      $display("stream %0d: data=%0h count=%0d", k, o_data, o_count);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("stream_end_empty", 32'(o_empty), 32'd1);

    // Flush with simultaneous push and pop; 0xAA must never emerge.
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 8'(8'hA0 + k), 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 8'hAA, 1'b1);
    chk("flush_count", 32'(o_count), 32'd0);
    chk("flush_vld",   32'(o_vld),   32'd0);
    chk("flush_rdy",   32'(o_rdy),   32'd1);
    $display("flush: count=%0d vld=%0b", o_count, o_vld);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("flush_idle_vld", 32'(o_vld), 32'd0);
    end

    // Reset mid-stream, then the first push is visible one cycle later.
    cycle(1'b0, 1'b0, 1'b1, 8'h01, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h02, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 8'h03, 1'b1);
    chk("midrst_count", 32'(o_count), 32'd0);
    chk("midrst_vld",   32'(o_vld),   32'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
    chk("midrst_data",  32'(o_data),  32'h5A);
    chk("midrst_vld2",  32'(o_vld),   32'd1);
    $display("reset mid-op: data=%0h vld=%0b", o_data, o_vld);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Random traffic against the queue model, with rare flush and reset.
    for (int k = 0; k < 400; k++) begin
      logic rr, ff, vv, dd_r;
      logic [7:0] dd;
      rr   = ($urandom_range(0, 99) < 2);
      ff   = ($urandom_range(0, 99) < 4);
      vv   = ($urandom_range(0, 99) < 65);
      dd_r = ($urandom_range(0, 99) < 50);
      dd   = 8'($urandom);
      cycle(rr, ff, vv, dd, dd_r);
      if (k % 40 == 0) $display("random %0d: count=%0d model=%0d", k, o_count, mq.size());
    end
    @(negedge i_clk);
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
